// File: rtl/lvds_word_aligner.sv
// Word aligner for a 1x12 deserializer: slips until TRAIN_PATTERN is seen MATCH_COUNT times, then forwards words.
// DATA_OUT lags Q_IN by 2 edges; there is no backpressure, BITSLIP is a single-cycle pulse decoded from state.
module lvds_word_aligner #(
    parameter int               WIDTH         = 12,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 12'hFC0,
    parameter int               SETTLE_CYCLES = 4,
    parameter int               MATCH_COUNT   = 16,
    parameter int               MAX_SLIPS     = 12,
    parameter int               LOSS_THRESH   = 4
) (
    input  logic             clkdiv_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] q_in_i,
    output logic             bitslip_o,
    output logic [WIDTH-1:0] data_out_o,
    output logic             data_valid_o,
    output logic             locked_o,
    output logic             fail_o,
    output logic [4:0]       slip_cnt_o
);

    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCK,
        S_FAILED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] data_q;
    logic [MW-1:0]    match_q, match_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [LW-1:0]    loss_q, loss_d;
    logic [4:0]       slip_q, slip_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             hit;

    assign hit = (q_q == TRAIN_PATTERN);

    always_ff @(posedge clkdiv_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_q    <= '0;
            data_q <= '0;
        end else begin
            q_q    <= q_in_i;
            data_q <= q_q;
        end
    end

    always_ff @(posedge clkdiv_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            match_q  <= '0;
            settle_q <= '0;
            loss_q   <= '0;
            slip_q   <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            settle_q <= settle_d;
            loss_q   <= loss_d;
            slip_q   <= slip_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    // settle and loss counters only live inside their own state, so they default to zero
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        settle_d = '0;
        loss_d   = '0;
        slip_d   = slip_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SETTLE;
                    slip_d  = '0;
                    match_d = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q >= SW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_CHECK: begin
                if (hit) begin
                    if (match_q < MW'(MATCH_COUNT)) begin
                        match_d = match_q + MW'(1);
                    end
                    if (match_q >= MW'(MATCH_COUNT - 1)) begin
                        state_d  = S_LOCK;
                        locked_d = 1'b1;
                    end
                end else begin
                    match_d = '0;
                    if (slip_q >= 5'(MAX_SLIPS)) begin
                        state_d = S_FAILED;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = S_SLIP;
                    end
                end
            end
            S_SLIP: begin
                if (slip_q != 5'h1F) begin
                    slip_d = slip_q + 5'd1;
                end
                state_d = S_SETTLE;
            end
            S_LOCK: begin
                if (start_i) begin
                    state_d  = S_SETTLE;
                    slip_d   = '0;
                    match_d  = '0;
                    locked_d = 1'b0;
                end else if (!hit) begin
                    if (loss_q >= LW'(LOSS_THRESH - 1)) begin
                        state_d  = S_SETTLE;
                        slip_d   = '0;
                        match_d  = '0;
                        locked_d = 1'b0;
                    end else begin
                        loss_d = loss_q + LW'(1);
                    end
                end
            end
            S_FAILED: begin
                if (start_i) begin
                    state_d = S_SETTLE;
                    slip_d  = '0;
                    match_d = '0;
                    fail_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bitslip_o    = (state_q == S_SLIP);
    assign data_valid_o = (state_q == S_LOCK);
    assign data_out_o   = data_q;
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;
    assign slip_cnt_o   = slip_q;

endmodule

// File: tb/tb_lvds_word_aligner.sv
// Bench for lvds_word_aligner: predicted event times (slip/lock/fail edges) are queued per scenario
// and matched by a monitor; DATA_OUT is scoreboarded against the Q_IN history.
module tb_lvds_word_aligner;

    localparam logic [11:0] PAT = 12'hFC0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] q_in;
    logic        bitslip;
    logic [11:0] data_out;
    logic        data_valid;
    logic        locked;
    logic        fail;
    logic [4:0]  slip_cnt;

    lvds_word_aligner dut (
        .clkdiv_i    (clk),
        .rstn_i      (rst_n),
        .start_i     (start),
        .q_in_i      (q_in),
        .bitslip_o   (bitslip),
        .data_out_o  (data_out),
        .data_valid_o(data_valid),
        .locked_o    (locked),
        .fail_o      (fail),
        .slip_cnt_o  (slip_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_SLIP, EV_LOCK, EV_UNLOCK, EV_FAIL, EV_UNFAIL} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       at;
    } ev_t;

    ev_t         exp_q[$];
    logic [11:0] hist[$];
    int          checks = 0;
    int          errors = 0;

    // stimulus state: word the "deserializer" presents, optional glitch override
    logic [11:0] word;
    logic [11:0] glitch_val;
    logic        glitch_on;
    logic        rot_en;
    int          rot_cd;

    function automatic void check(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [11:0] rotl(input logic [11:0] x);
        return {x[10:0], x[11]};
    endfunction

    function automatic logic [11:0] rand_bad();
        logic [11:0] v;
        do v = 12'($urandom_range(0, 4095)); while (v == PAT);
        return v;
    endfunction

    task automatic push(input ev_kind_t k, input int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic ev_seen(input ev_kind_t k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d at cycle %0d, want none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d at cycle %0d, want kind %0d at cycle %0d",
                         k, cyc, e.kind, e.at);
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        hist.push_back(q_in);
        if (hist.size() > 4) void'(hist.pop_front());
    end

    logic p_slip = 1'b0, p_lock = 1'b0, p_fail = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_slip = 1'b0;
            p_lock = 1'b0;
            p_fail = 1'b0;
        end else begin
            check("excl", int'(locked & fail), 0);
            check("valid_eq_lock", int'(data_valid), int'(locked));
            if (data_valid && hist.size() >= 2)
                check("data_out", int'(data_out), int'(hist[hist.size()-2]));
            if (bitslip) check("slip_width", int'(p_slip), 0);
            if (bitslip && !p_slip) ev_seen(EV_SLIP);
            if (locked && !p_lock)  ev_seen(EV_LOCK);
            if (!locked && p_lock)  ev_seen(EV_UNLOCK);
            if (fail && !p_fail)    ev_seen(EV_FAIL);
            if (!fail && p_fail)    ev_seen(EV_UNFAIL);
            p_slip = bitslip;
            p_lock = locked;
            p_fail = fail;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive();
        q_in = glitch_on ? glitch_val : word;
    endtask

    // deserializer model: the word rotates left by one, 2 edges after a BITSLIP is seen
    task automatic tick();
        @(negedge clk);
        if (rot_en) begin
            if (rot_cd == 1) word = rotl(word);
            if (rot_cd > 0) rot_cd--;
            if (bitslip) rot_cd = 2;
        end
        drive();
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic glitch_at(input int first, input int n);
        wait_cyc(first - 1);
        glitch_on = 1'b1;
        for (int i = 0; i < n; i++) begin
            glitch_val = rand_bad();
            drive();
            tick();
        end
        glitch_on = 1'b0;
        drive();
    endtask

    task automatic run_rotate(input int k, input bit from_lock);
        int s;
        logic [11:0] w;
        w = PAT;
        repeat (12 - k) w = rotl(w);
        word   = w;
        rot_en = 1'b1;
        rot_cd = 0;
        drive();
        s = cyc + 1;
        if (from_lock) push(EV_UNLOCK, s);
        for (int j = 0; j < k; j++) push(EV_SLIP, s + 5 + 6 * j);
        push(EV_LOCK, s + 20 + 6 * k);
        pulse_start();
        wait_cyc(s + 21 + 6 * k);
        check("rot_slip_cnt", int'(slip_cnt), k);
        check("rot_locked", int'(locked), 1);
    endtask

    initial begin
        int s, f, n, g;
        rst_n = 1'b0; start = 1'b0; q_in = '0; word = '0;
        glitch_on = 1'b0; glitch_val = '0; rot_en = 1'b0; rot_cd = 0;
        #12;
        check("rst_bitslip", int'(bitslip), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_slip_cnt", int'(slip_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // aligned input from IDLE: lock 20 edges after START
        word = PAT; drive();
        s = cyc + 1;
        push(EV_LOCK, s + 20);
        pulse_start();
        wait_cyc(s + 19);
        check("align_not_yet", int'(locked), 0);
        tick();
        check("align_locked", int'(locked), 1);
        check("align_slip_cnt", int'(slip_cnt), 0);

        // rotated input: fixed offset 3, then random offsets, each restarted from LOCK
        run_rotate(3, 1'b1);
        repeat (2) run_rotate(int'($urandom_range(1, 11)), 1'b1);

        // loss of lock: short mismatch bursts keep lock
        repeat (2) begin
            n = int'($urandom_range(1, 3));
            f = cyc + 3;
            glitch_at(f, n);
            wait_cyc(f + n + 3);
            check("loss_short_locked", int'(locked), 1);
        end
        // four consecutive mismatches drop lock; re-acquire without START
        f = cyc + 3;
        push(EV_UNLOCK, f + 4);
        push(EV_LOCK, f + 24);
        glitch_at(f, 4);
        wait_cyc(f + 4);
        check("loss_valid", int'(data_valid), 0);
        check("loss_slip_cnt", int'(slip_cnt), 0);
        wait_cyc(f + 25);
        check("reacq_locked", int'(locked), 1);

        // single glitch during CHECK after g matches
        rot_en = 1'b0; word = PAT; drive();
        g = int'($urandom_range(1, 15));
        s = cyc + 1;
        push(EV_UNLOCK, s);
        push(EV_SLIP, s + 5 + g);
        push(EV_LOCK, s + 26 + g);
        pulse_start();
        glitch_at(s + 4 + g, 1);
        wait_cyc(s + 27 + g);
        check("glitch_slip_cnt", int'(slip_cnt), 1);
        check("glitch_locked", int'(locked), 1);

        // never-matching input: 12 slips then FAIL; new START clears FAIL
        word = '0; drive();
        s = cyc + 1;
        push(EV_UNLOCK, s);
        for (int j = 0; j < 12; j++) push(EV_SLIP, s + 5 + 6 * j);
        push(EV_FAIL, s + 77);
        pulse_start();
        wait_cyc(s + 80);
        check("fail_flag", int'(fail), 1);
        check("fail_locked", int'(locked), 0);
        check("fail_slip_cnt", int'(slip_cnt), 12);
        word = PAT; drive();
        s = cyc + 1;
        push(EV_UNFAIL, s);
        push(EV_LOCK, s + 20);
        pulse_start();
        wait_cyc(s + 21);
        check("refail_locked", int'(locked), 1);
        check("refail_slip_cnt", int'(slip_cnt), 0);

        // reset asserted while BITSLIP is high
        word = '0; drive();
        s = cyc + 1;
        push(EV_UNLOCK, s);
        push(EV_SLIP, s + 5);
        pulse_start();
        wait_cyc(s + 5);
        check("pre_rst_bitslip", int'(bitslip), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bitslip", int'(bitslip), 0);
        check("mid_rst_data_out", int'(data_out), 0);
        check("mid_rst_valid", int'(data_valid), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_fail", int'(fail), 0);
        check("mid_rst_slip_cnt", int'(slip_cnt), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("idle_slip_cnt", int'(slip_cnt), 0);
        check("idle_fail", int'(fail), 0);

        check("events_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
